// File: rtl/circuit_4_5_pkg.sv
// Shared definitions for the circuit_4_5 self-test engine.
// Holds the FSM state encoding, the golden ABC table of the converter,
// and the MISR seed, feedback tap mask and fault-free signature.
package circuit_4_5_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        APPLY = 3'd1,
        WAIT  = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [7:0] MISR_SEED   = 8'hFF;
    // Feedback taps at bits 7,5,4,3.
    localparam logic [7:0] MISR_TAPS   = 8'hB8;
    // Signature of a complete fault-free sweep.
    localparam logic [7:0] MISR_GOLDEN = 8'h04;

    // Expected {A,B,C} of a fault-free converter for input vector {x,y,z}.
    function automatic logic [2:0] golden_abc(input logic [2:0] vec);
        logic [2:0] abc;
        case (vec)
            3'd0:    abc = 3'd2;
            3'd1:    abc = 3'd3;
            3'd2:    abc = 3'd4;
            3'd3:    abc = 3'd5;
            3'd4:    abc = 3'd1;
            3'd5:    abc = 3'd2;
            3'd6:    abc = 3'd3;
            default: abc = 3'd4;
        endcase
        return abc;
    endfunction

endpackage

// File: rtl/circuit_4_5_misr.sv
// 8-bit multiple-input signature register compacting the sampled ABC responses.
// Ports: clk, rst (sync, active-high), clear (load seed), enable (absorb data), data[2:0], sig[7:0].
// Latency: sig reflects a clear/enable on the following edge; clear wins over enable.
module circuit_4_5_misr
    import circuit_4_5_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [2:0] data,
    output logic [7:0] sig
);

    logic feedback;

    assign feedback = ^(sig & MISR_TAPS);

    always_ff @(posedge clk) begin
        if (rst) begin
            sig <= 8'h00;
        end else if (clear) begin
            sig <= MISR_SEED;
        end else if (enable) begin
            sig <= {sig[6:0], feedback} ^ {5'b0, data};
        end
    end

endmodule

// File: rtl/circuit_4_5_bist.sv
// Closed-loop self-test for the circuit_4_5 converter: sweeps x,y,z over all 8
// vectors, waits SETTLE_CYCLES after each, samples A,B,C and checks the golden table.
// Ports: clk, rst, start in; x,y,z out; A,B,C in; busy/done/pass/err_count/fail_vld/fail_vec/sig out.
// Optional MISR signature on sig when CIRCUIT_4_5_BIST_MISR_EN is defined, else sig is 0.
module circuit_4_5_bist
    import circuit_4_5_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             x,
    output logic             y,
    output logic             z,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             fail_vld,
    output logic [2:0]       fail_vec,
    output logic [7:0]       sig
);

    localparam logic [3:0]       SETTLE  = 4'(SETTLE_CYCLES);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t     state, state_nxt;
    logic [2:0] vec;
    logic [3:0] cnt;
    logic       launch, load_cnt, dec_cnt, check_en, finish;
    logic       mismatch;

    assign {x, y, z} = vec;
    assign mismatch  = ({A, B, C} != golden_abc(vec));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // DONE is entered with busy still high; the first DONE cycle publishes the
    // result, so a start held high is only honoured from the following cycle.
    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        load_cnt  = 1'b0;
        dec_cnt   = 1'b0;
        check_en  = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                load_cnt  = 1'b1;
                state_nxt = (SETTLE_CYCLES == 0) ? CHECK : WAIT;
            end
            WAIT: begin
                dec_cnt = 1'b1;
                if (cnt == 4'd1) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                check_en  = 1'b1;
                state_nxt = (vec == 3'd7) ? DONE : APPLY;
            end
            DONE: begin
                if (busy) begin
                    finish = 1'b1;
                end else if (start) begin
                    launch    = 1'b1;
                    state_nxt = APPLY;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= 3'd0;
            cnt       <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vld  <= 1'b0;
            fail_vec  <= 3'd0;
        end else begin
            if (launch) begin
                vec       <= 3'd0;
                busy      <= 1'b1;
                done      <= 1'b0;
                pass      <= 1'b0;
                err_count <= '0;
                fail_vld  <= 1'b0;
                fail_vec  <= 3'd0;
            end
            if (load_cnt) begin
                cnt <= SETTLE;
            end else if (dec_cnt) begin
                cnt <= cnt - 4'd1;
            end
            if (check_en) begin
                if (mismatch) begin
                    if (err_count != ERR_MAX) begin
                        err_count <= err_count + ERR_W'(1);
                    end
                    if (!fail_vld) begin
                        fail_vld <= 1'b1;
                        fail_vec <= vec;
                    end
                end
                if (vec != 3'd7) begin
                    vec <= vec + 3'd1;
                end
            end
            if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_count == '0);
            end
        end
    end

`ifdef CIRCUIT_4_5_BIST_MISR_EN
    circuit_4_5_misr u_misr (
        .clk    (clk),
        .rst    (rst),
        .clear  (launch),
        .enable (check_en),
        .data   ({A, B, C}),
        .sig    (sig)
    );
`else
    assign sig = 8'h00;
`endif

endmodule

// File: tb/tb_circuit_4_5_bist.sv
// Self-checking bench for circuit_4_5_bist: three engines (default, SETTLE_CYCLES=0,
// ERR_W=3) each check a behavioural converter model whose outputs can be corrupted
// per vector; results are compared against a table and a higher-level reference model.
module tb_circuit_4_5_bist;

    localparam logic [2:0] GOLD [8] = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1, 3'd2, 3'd3, 3'd4};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [2:0] mask [8];

    // Instance a: defaults. Instance b: SETTLE_CYCLES=0. Instance c: ERR_W=3.
    logic x_a, y_a, z_a, A_a, B_a, C_a, busy_a, done_a, pass_a, fvld_a;
    logic [3:0] err_a;
    logic [2:0] fvec_a;
    logic [7:0] sig_a;
    logic x_b, y_b, z_b, A_b, B_b, C_b, busy_b, done_b, pass_b, fvld_b;
    logic [3:0] err_b;
    logic [2:0] fvec_b;
    logic [7:0] sig_b;
    logic x_c, y_c, z_c, A_c, B_c, C_c, busy_c, done_c, pass_c, fvld_c;
    logic [2:0] err_c;
    logic [2:0] fvec_c;
    logic [7:0] sig_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Converter models, with the per-vector fault mask applied.
    always_comb {A_a, B_a, C_a} = GOLD[{x_a, y_a, z_a}] ^ mask[{x_a, y_a, z_a}];
    always_comb {A_b, B_b, C_b} = GOLD[{x_b, y_b, z_b}] ^ mask[{x_b, y_b, z_b}];
    always_comb {A_c, B_c, C_c} = GOLD[{x_c, y_c, z_c}] ^ mask[{x_c, y_c, z_c}];

    circuit_4_5_bist #(.SETTLE_CYCLES(1), .ERR_W(4)) dut_a (
        .clk(clk), .rst(rst), .start(start), .x(x_a), .y(y_a), .z(z_a),
        .A(A_a), .B(B_a), .C(C_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_vld(fvld_a), .fail_vec(fvec_a), .sig(sig_a));

    circuit_4_5_bist #(.SETTLE_CYCLES(0), .ERR_W(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .x(x_b), .y(y_b), .z(z_b),
        .A(A_b), .B(B_b), .C(C_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_vld(fvld_b), .fail_vec(fvec_b), .sig(sig_b));

    circuit_4_5_bist #(.SETTLE_CYCLES(1), .ERR_W(3)) dut_c (
        .clk(clk), .rst(rst), .start(start), .x(x_c), .y(y_c), .z(z_c),
        .A(A_c), .B(B_c), .C(C_c), .busy(busy_c), .done(done_c), .pass(pass_c),
        .err_count(err_c), .fail_vld(fvld_c), .fail_vec(fvec_c), .sig(sig_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // 0: fault-free, 1: A stuck-at-0, 2: all outputs inverted
    task automatic set_mode(input int mode);
        for (int v = 0; v < 8; v++) begin
            case (mode)
                1:       mask[v] = GOLD[v] & 3'b100;
                2:       mask[v] = 3'b111;
                default: mask[v] = 3'b000;
            endcase
        end
    endtask

    // Reference model: counts differing vectors, first failure, and signature.
    task automatic model(output int nerr, output bit fv, output int fvec, output logic [7:0] s);
        logic [2:0] resp;
        nerr = 0;
        fv = 1'b0;
        fvec = 0;
        s = 8'hFF;
        for (int v = 0; v < 8; v++) begin
            resp = GOLD[v] ^ mask[v];
            if (mask[v] != 3'b000) begin
                nerr++;
                if (!fv) begin
                    fv = 1'b1;
                    fvec = v;
                end
            end
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {5'b0, resp};
        end
    endtask

    // Pulses start and measures edges from the start-sampling edge to done.
    task automatic run(output int la, output int lb, output int lc);
        la = -1;
        lb = -1;
        lc = -1;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", {31'b0, busy_a}, 1);
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done_a && la < 0) la = n;
            if (done_b && lb < 0) lb = n;
            if (done_c && lc < 0) lc = n;
            if (la >= 0 && lb >= 0 && lc >= 0) break;
        end
    endtask

    task automatic check_results(input string tag, input int e4, input int e3, input bit fv,
                                 input int fvec, input bit ps, input logic [7:0] s);
        int la, lb, lc;
        logic [7:0] exp_sig;
`ifdef CIRCUIT_4_5_BIST_MISR_EN
        exp_sig = s;
`else
        exp_sig = 8'h00;
`endif
        run(la, lb, lc);
        chk({tag, " latency_a"}, la, 25);
        chk({tag, " latency_b"}, lb, 17);
        chk({tag, " latency_c"}, lc, 25);
        chk({tag, " busy_a"}, {31'b0, busy_a}, 0);
        chk({tag, " pass_a"}, {31'b0, pass_a}, {31'b0, ps});
        chk({tag, " err_a"}, {28'b0, err_a}, e4);
        chk({tag, " fvld_a"}, {31'b0, fvld_a}, {31'b0, fv});
        if (fv) chk({tag, " fvec_a"}, {29'b0, fvec_a}, fvec);
        chk({tag, " xyz_a"}, {29'b0, x_a, y_a, z_a}, 7);
        chk({tag, " sig_a"}, {24'b0, sig_a}, {24'b0, exp_sig});
        chk({tag, " pass_b"}, {31'b0, pass_b}, {31'b0, ps});
        chk({tag, " err_b"}, {28'b0, err_b}, e4);
        chk({tag, " sig_b"}, {24'b0, sig_b}, {24'b0, exp_sig});
        chk({tag, " err_c"}, {29'b0, err_c}, e3);
        chk({tag, " pass_c"}, {31'b0, pass_c}, {31'b0, ps});
        if (fv) chk({tag, " fvec_c"}, {29'b0, fvec_c}, fvec);
    endtask

    typedef struct {
        int mode;
        int err4;
        int err3;
        bit fvld;
        int fvec;
        bit pass;
    } vec_t;

    initial begin
        vec_t tbl [3];
        int nerr, fvec, found;
        bit fv;
        logic [7:0] s;
        int la, lb, lc;

        tbl[0] = '{mode: 0, err4: 0, err3: 0, fvld: 1'b0, fvec: 0, pass: 1'b1};
        tbl[1] = '{mode: 1, err4: 3, err3: 3, fvld: 1'b1, fvec: 2, pass: 1'b0};
        tbl[2] = '{mode: 2, err4: 8, err3: 7, fvld: 1'b1, fvec: 0, pass: 1'b0};

        set_mode(0);
        do_reset();
        #1;
        chk("rst busy", {31'b0, busy_a}, 0);
        chk("rst done", {31'b0, done_a}, 0);
        chk("rst pass", {31'b0, pass_a}, 0);
        chk("rst err", {28'b0, err_a}, 0);
        chk("rst fvld", {31'b0, fvld_a}, 0);
        chk("rst fvec", {29'b0, fvec_a}, 0);
        chk("rst xyz", {29'b0, x_a, y_a, z_a}, 0);
        chk("rst sig", {24'b0, sig_a}, 0);

        // Table-driven fault scenarios.
        for (int i = 0; i < 3; i++) begin
            set_mode(tbl[i].mode);
            model(nerr, fv, fvec, s);
            check_results($sformatf("tbl%0d", i), tbl[i].err4, tbl[i].err3, tbl[i].fvld,
                          tbl[i].fvec, tbl[i].pass, s);
        end
`ifdef CIRCUIT_4_5_BIST_MISR_EN
        set_mode(0);
        check_results("golden_sig", 0, 0, 1'b0, 0, 1'b1, 8'h04);
`endif

        // Reset mid-run, at vector 4, with A stuck-at-0.
        set_mode(1);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int n = 0; n < 40; n++) begin
            if ({x_a, y_a, z_a} == 3'd4) begin
                found = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("midrun reached_vec4", found, 1);
        chk("midrun err_before_rst", {28'b0, err_a}, 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun busy", {31'b0, busy_a}, 0);
        chk("midrun xyz", {29'b0, x_a, y_a, z_a}, 0);
        chk("midrun err", {28'b0, err_a}, 0);
        chk("midrun fvld", {31'b0, fvld_a}, 0);
        chk("midrun done", {31'b0, done_a}, 0);
        chk("midrun sig", {24'b0, sig_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        set_mode(0);
        model(nerr, fv, fvec, s);
        check_results("after_rst", 0, 0, 1'b0, 0, 1'b1, s);

        // start held high: ignored while busy, relaunches from DONE.
        set_mode(2);
        @(negedge clk);
        start = 1'b1;
        la = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                la = n - 1;
                break;
            end
        end
        chk("held latency", la, 25);
        chk("held err_at_done", {28'b0, err_a}, 8);
        chk("held busy_at_done", {31'b0, busy_a}, 0);
        @(posedge clk);
        #1;
        chk("held relaunch done", {31'b0, done_a}, 0);
        chk("held relaunch err", {28'b0, err_a}, 0);
        chk("held relaunch xyz", {29'b0, x_a, y_a, z_a}, 0);
        chk("held relaunch busy", {31'b0, busy_a}, 1);
        start = 1'b0;
        do_reset();

        // Randomised fault masks against the reference model.
        for (int it = 0; it < 12; it++) begin
            for (int v = 0; v < 8; v++) begin
                if ((it % 4) == 3 || $urandom_range(0, 1) == 0) mask[v] = 3'b000;
                else mask[v] = 3'($urandom_range(1, 7));
            end
            model(nerr, fv, fvec, s);
            check_results($sformatf("rnd%0d", it), (nerr > 15) ? 15 : nerr,
                          (nerr > 7) ? 7 : nerr, fv, fvec, (nerr == 0), s);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
